// File: rtl/fp32_pkg.sv
// Shared definitions for the sequential FP32 divider: FSM encodings, FP32 constants
// and operand class decoders.
package fp32_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int          EXP_BIAS  = 127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam int          QUOT_BITS = 26;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
    endfunction

    // Subnormals have a zero exponent and are treated as zero.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'd0);
    endfunction

endpackage

// File: rtl/fp32_mant_div_step.sv
// Combinational restoring-division stage producing RADIX_BITS quotient bits,
// most significant first; the remainder is doubled after each compare.
module fp32_mant_div_step
    import fp32_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic [24:0]           i_rem,
    input  logic [23:0]           i_div,
    output logic [24:0]           o_rem,
    output logic [RADIX_BITS-1:0] o_q
);

    logic [24:0] w_rem;

    // Chain of compare/subtract/shift steps.
    always_comb begin
        w_rem = i_rem;
        o_q   = '0;
        for (int i = RADIX_BITS - 1; i >= 0; i--) begin
            if (w_rem >= {1'b0, i_div}) begin
                o_q[i] = 1'b1;
                w_rem  = w_rem - {1'b0, i_div};
            end else begin
                o_q[i] = 1'b0;
            end
            w_rem = {w_rem[23:0], 1'b0};
        end
        o_rem = w_rem;
    end

endmodule

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider with start/done handshake.
// Optional round-to-nearest-even in NORM: define FP32_DIV_ROUND_NEAREST_EN.
module fp32_divider
    import fp32_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quotient_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        div_by_zero_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    localparam logic [4:0] LAST_CNT = 5'(QUOT_BITS / RADIX_BITS - 1);

    logic [2:0]            r_state, w_state_nxt;
    logic [31:0]           r_a, r_b, r_quotient;
    logic signed [9:0]     r_exp;
    logic [24:0]           r_rem, w_rem_nxt;
    logic [23:0]           r_div;
    logic [QUOT_BITS-1:0]  r_quot;
    logic [4:0]            r_cnt;
    logic [RADIX_BITS-1:0] w_q_bits;
    logic                  r_done, r_busy, r_nan, r_inf, r_dbz, r_ovf, r_unf;
    logic                  w_sign, w_special;
    logic [31:0]           w_spec_q;
    logic [2:0]            w_spec_fl;
    logic [22:0]           w_frac, w_frac_fin;
    logic signed [9:0]     w_exp_n, w_exp_fin;

    fp32_mant_div_step #(.RADIX_BITS(RADIX_BITS)) u_step (
        .i_rem (r_rem),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_q   (w_q_bits)
    );

    // Special-operand classification; first match wins.
    always_comb begin
        w_sign    = r_a[31] ^ r_b[31];
        w_special = 1'b1;
        w_spec_q  = 32'd0;
        w_spec_fl = 3'b000;
        if (is_nan(r_a) || is_nan(r_b) || (is_zero(r_a) && is_zero(r_b))
            || (is_inf(r_a) && is_inf(r_b))) begin
            w_spec_q  = QNAN;
            w_spec_fl = 3'b100;
        end else if (is_inf(r_a)) begin
            w_spec_q  = {w_sign, POS_INF[30:0]};
            w_spec_fl = 3'b010;
        end else if (is_inf(r_b)) begin
            w_spec_q  = {w_sign, 31'd0};
        end else if (is_zero(r_b)) begin
            w_spec_q  = {w_sign, POS_INF[30:0]};
            w_spec_fl = 3'b001;
        end else if (is_zero(r_a)) begin
            w_spec_q  = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // Normalisation of the raw quotient and optional rounding.
`ifdef FP32_DIV_ROUND_NEAREST_EN
    logic        w_guard, w_sticky, w_round_up;
    logic [23:0] w_frac_sum;
`endif
    always_comb begin
        if (r_quot[QUOT_BITS-1]) begin
            w_frac  = r_quot[24:2];
            w_exp_n = r_exp;
        end else begin
            w_frac  = r_quot[23:1];
            w_exp_n = r_exp - 10'sd1;
        end
`ifdef FP32_DIV_ROUND_NEAREST_EN
        if (r_quot[QUOT_BITS-1]) begin
            w_guard  = r_quot[1];
            w_sticky = r_quot[0] | (r_rem != 25'd0);
        end else begin
            w_guard  = r_quot[0];
            w_sticky = (r_rem != 25'd0);
        end
        w_round_up = w_guard & (w_sticky | w_frac[0]);
        w_frac_sum = {1'b0, w_frac} + {23'd0, w_round_up};
        w_frac_fin = w_frac_sum[22:0];
        w_exp_fin  = w_exp_n + (w_frac_sum[23] ? 10'sd1 : 10'sd0);
`else
        w_frac_fin = w_frac;
        w_exp_fin  = w_exp_n;
`endif
    end

    // Next-state decode.
    always_comb begin
        case (r_state)
            S_IDLE:   w_state_nxt = start_i ? S_CHECK : S_IDLE;
            S_CHECK:  w_state_nxt = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: w_state_nxt = (r_cnt == LAST_CNT) ? S_NORM : S_DIVIDE;
            S_NORM:   w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and registered result/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_exp      <= 10'sd0;
            r_rem      <= 25'd0;
            r_div      <= 24'd0;
            r_quot     <= '0;
            r_cnt      <= 5'd0;
            r_quotient <= 32'd0;
            {r_nan, r_inf, r_dbz, r_ovf, r_unf} <= 5'b00000;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a        <= a_i;
                        r_b        <= b_i;
                        r_quotient <= 32'd0;
                        {r_nan, r_inf, r_dbz, r_ovf, r_unf} <= 5'b00000;
                    end
                end
                S_CHECK: begin
                    if (w_special) begin
                        r_quotient             <= w_spec_q;
                        {r_nan, r_inf, r_dbz}  <= w_spec_fl;
                    end else begin
                        r_rem  <= {2'b01, r_a[22:0]};
                        r_div  <= {1'b1, r_b[22:0]};
                        r_exp  <= $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]})
                                  + 10'(EXP_BIAS);
                        r_cnt  <= 5'd0;
                        r_quot <= '0;
                    end
                end
                S_DIVIDE: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= {r_quot[QUOT_BITS-1-RADIX_BITS:0], w_q_bits};
                    r_cnt  <= (r_cnt == LAST_CNT) ? 5'd0 : r_cnt + 5'd1;
                end
                S_NORM: begin
                    if (w_exp_fin >= 10'sd255) begin
                        r_quotient <= {w_sign, POS_INF[30:0]};
                        r_ovf      <= 1'b1;
                    end else if (w_exp_fin <= 10'sd0) begin
                        r_quotient <= {w_sign, 31'd0};
                        r_unf      <= 1'b1;
                    end else begin
                        r_quotient <= {w_sign, w_exp_fin[7:0], w_frac_fin};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient_o    = r_quotient;
    assign done_o        = r_done;
    assign busy_o        = r_busy;
    assign nan_o         = r_nan;
    assign infinit_o     = r_inf;
    assign div_by_zero_o = r_dbz;
    assign overflow_o    = r_ovf;
    assign underflow_o   = r_unf;

endmodule

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
Sequential IEEE-754 single-precision divider: quotient_o = a_i / b_i. It is the companion to the team's FP32 multiplier and uses the same start/done handshake and flag style, so the two can sit side by side in the FP unit. The mantissa is computed by iterative restoring division, RADIX_BITS quotient bits per cycle. Subnormal inputs and results are flushed to zero.

Parameters:
RADIX_BITS, 1, quotient bits produced per DIVIDE cycle; legal values 1 or 2; DIVIDE lasts 26/RADIX_BITS cycles.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
start_i  in  1  request a new division; sampled only in IDLE
a_i  in  32  dividend (FP32)
b_i  in  32  divisor (FP32)
quotient_o  out  32  result, registered; held until the next accepted start
done_o  out  1  one-cycle pulse, result and flags valid
busy_o  out  1  high in every state except IDLE
nan_o  out  1  NaN result
infinit_o  out  1  infinite operand produced an infinite result
div_by_zero_o  out  1  finite non-zero value divided by zero
overflow_o  out  1  result exponent too large
underflow_o  out  1  result exponent too small, flushed to zero

Behaviour:
- Reset (async, any state, including mid-division): state=IDLE; quotient_o=0; all flags=0; done_o=0; busy_o=0.
- States: IDLE -> CHECK -> DIVIDE -> NORM -> DONE -> IDLE. Special cases take CHECK -> DONE.
- IDLE, start_i=1: a_i and b_i are captured into internal registers; quotient_o and all flags clear to 0. Operand changes after capture are ignored. start_i outside IDLE is ignored.
- CHECK (1 cycle). Decode: exp==0 means zero (subnormals count as zero); exp==FF with frac!=0 is NaN; exp==FF with frac==0 is inf. sign = sa^sb. Priority, first match wins:
  - any NaN, 0/0, or inf/inf -> 0x7FC00000, nan_o=1
  - inf/finite -> {sign,FF,0}, infinit_o=1
  - finite/inf -> {sign,0}
  - nonzero/0 -> {sign,FF,0}, div_by_zero_o=1
  - 0/nonzero -> {sign,0}
  - otherwise -> DIVIDE. Load remainder = {1,fa}, divisor = {1,fb}, exponent e = ea - eb + 127 in 10-bit signed arithmetic, iteration counter = 0.
- DIVIDE: each step doubles the remainder after the compare, so quotient bits come out at weights 2^0, 2^-1, ... Per bit: if remainder >= divisor, then q=1 and remainder -= divisor; else q=0. Then remainder <<= 1. Together this produces Q[25:0] with Q[25] at weight 2^0. The counter wraps to exit after exactly 26/RADIX_BITS cycles.
- NORM (1 cycle):
  - Q[25]=1: frac = Q[24:2], guard = Q[1], sticky = Q[0] | (rem!=0).
  - Q[25]=0: frac = Q[23:1], guard = Q[0], sticky = (rem!=0), e = e-1.
  - Default rounding is truncation.
  - e >= 255 -> {sign,FF,0}, overflow_o=1.
  - e <= 0 -> {sign,0}, underflow_o=1.
  - otherwise -> {sign, e[7:0], frac}.
- DONE (1 cycle): done_o=1, then IDLE. start_i asserted during DONE is ignored; it is accepted on the following IDLE cycle.
- Latency, counting the start-sampling edge as edge 0:
  - normal path: done_o is sampled high at edge 3+26/RADIX_BITS (29 for RADIX_BITS=1, 16 for RADIX_BITS=2).
  - special-case path: done_o is sampled high at edge 2.
- Flags are mutually exclusive and remain valid after done_o until the next accepted start.

Optional Feature:
FP32_DIV_ROUND_NEAREST_EN
- Defined: NORM applies round-to-nearest-even. Increment when guard & (sticky | frac[0]). A mantissa carry-out increments e, and the overflow check runs after rounding.
- Undefined: truncation; guard and sticky logic is not synthesised.

Decomposition:
- Package fp32_pkg:
  - state enum: IDLE, CHECK, DIVIDE, NORM, DONE
  - constants: EXP_BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC00000, POS_INF=32'h7F800000, QUOT_BITS=26
  - functions: is_nan, is_inf, is_zero
- Sub-module fp32_mant_div_step: combinational restoring stage(s). Takes remainder and divisor; returns next remainder and RADIX_BITS quotient bits. Instantiated once by the FSM.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), RADIX_BITS=1 -> 0x40400000 with done_o sampled at edge 29 and no flags; repeat with RADIX_BITS=2 -> same result, done_o at edge 16.
- 0xC0C00000 / 0x40000000 -> 0xC0400000. 0x3F800000 / 0x40400000 -> 0x3EAAAAAA without the macro, 0x3EAAAAAB with it.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero_o=1, done_o at edge 2. 0x00000000 / 0x00000000 -> 0x7FC00000, nan_o=1. 0xFF800000 / 0x40000000 -> 0xFF800000, infinit_o=1.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow_o=1. 0x00800000 / 0x40000000 -> 0x00000000, underflow_o=1.
- rst_n low during DIVIDE -> all outputs 0 immediately; with no start_i after release, done_o never pulses. Next start with 6/2 -> 0x40400000.
- start_i pulsed during DIVIDE and held through DONE, with operands changed -> the first result is unaffected, and exactly one new operation is accepted in the IDLE cycle after DONE.
